// File: rtl/kiwi_chk_pkg.sv
// Shared types, default widths and the recurrence step for the Kiwi result stream checker.
package kiwi_chk_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_CNT_W  = 16;

   typedef enum logic [0:0] {
      CHECK = 1'b0,
      DONE  = 1'b1
   } chk_state_t;

   // Product modulo 2^64; callers truncate to their own data width (valid up to 64 bits).
   function automatic logic [63:0] next_expected(input logic [63:0] value, input logic [63:0] mult);
      return value * mult;
   endfunction

endpackage

// File: rtl/kiwi_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and no fall-through; DEPTH must be a power of two.
module kiwi_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_next;
   logic             do_push;
   logic             do_pop;

   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign occ_next = occ + OCC_W'(do_push) - OCC_W'(do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         occ   <= occ_next;
         full  <= (occ_next == OCC_W'(DEPTH));
         empty <= (occ_next == '0);
      end
   end

endmodule

// File: rtl/kiwi_result_stream_checker.sv
// Self-checking sink for the Kiwi result stream: v[0]=SEED, v[n+1]=v[n]*MULT mod 2^DATA_W.
// Optional simulation trace of each checked value under KIWI_CHECKER_TRACE_EN.
module kiwi_result_stream_checker
   import kiwi_chk_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MULT       = 1001,
   parameter int unsigned SEED       = 1,
   parameter int unsigned MAX_ITEMS  = 0,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              clear,
   output logic [CNT_W-1:0]  match_count,
   output logic [CNT_W-1:0]  mismatch_count,
   output logic [CNT_W-1:0]  first_bad_idx,
   output logic [DATA_W-1:0] last_value,
   output logic              done,
   output logic              error
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   chk_state_t        state, state_n;
   logic [CNT_W-1:0]  match_n, mismatch_n, first_bad_n, idx, idx_n;
   logic [DATA_W-1:0] last_n, expected, expected_n;
   logic              done_n, error_n;
   logic              fifo_full, fifo_empty, push, pop;
   logic [DATA_W-1:0] fifo_data;

   assign in_ready = ~fifo_full;
   assign push     = in_valid & ~clear;
   assign pop      = (state == CHECK) & ~fifo_empty & ~clear;

   kiwi_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next-state and counter update; expected advances from itself so a bad value does not cascade.
   always_comb begin
      state_n     = state;
      match_n     = match_count;
      mismatch_n  = mismatch_count;
      first_bad_n = first_bad_idx;
      idx_n       = idx;
      last_n      = last_value;
      expected_n  = expected;
      done_n      = done;
      error_n     = error;
      if (clear) begin
         state_n     = CHECK;
         match_n     = '0;
         mismatch_n  = '0;
         first_bad_n = '0;
         idx_n       = '0;
         last_n      = '0;
         expected_n  = DATA_W'(SEED);
         done_n      = 1'b0;
         error_n     = 1'b0;
      end else if (pop) begin
         last_n     = fifo_data;
         expected_n = DATA_W'(next_expected(64'(expected), 64'(MULT)));
         idx_n      = (idx == CNT_MAX) ? idx : idx + CNT_W'(1);
         if (fifo_data == expected) begin
            match_n = (match_count == CNT_MAX) ? match_count : match_count + CNT_W'(1);
         end else begin
            mismatch_n = (mismatch_count == CNT_MAX) ? mismatch_count : mismatch_count + CNT_W'(1);
            if (!error) begin
               error_n     = 1'b1;
               first_bad_n = idx;
            end
         end
         if ((MAX_ITEMS != 0) && (32'(idx_n) == MAX_ITEMS)) begin
            state_n = DONE;
            done_n  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= CHECK;
         match_count    <= '0;
         mismatch_count <= '0;
         first_bad_idx  <= '0;
         idx            <= '0;
         last_value     <= '0;
         expected       <= DATA_W'(SEED);
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         state          <= state_n;
         match_count    <= match_n;
         mismatch_count <= mismatch_n;
         first_bad_idx  <= first_bad_n;
         idx            <= idx_n;
         last_value     <= last_n;
         expected       <= expected_n;
         done           <= done_n;
         error          <= error_n;
      end
   end

`ifdef KIWI_CHECKER_TRACE_EN
   always @(posedge clk) begin
      if (!reset && pop) begin
         $display("The value of the integer: %1d", fifo_data);
         if (fifo_data != expected) begin
            $display("MISMATCH idx=%1d exp=%1d got=%1d", idx, expected, fifo_data);
         end
      end
   end
`endif

endmodule

// File: tb/tb_kiwi_result_stream_checker.sv
// Directed bench for kiwi_result_stream_checker: unbounded instance (a) and MAX_ITEMS=2 instance (b).
module tb_kiwi_result_stream_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid_a, clear_a, in_ready_a, done_a, error_a;
   logic [31:0] in_data_a, last_value_a;
   logic [15:0] match_a, mismatch_a, first_bad_a;
   logic        in_valid_b, clear_b, in_ready_b, done_b, error_b;
   logic [31:0] in_data_b, last_value_b;
   logic [15:0] match_b, mismatch_b, first_bad_b;
   logic [31:0] chain [6];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   kiwi_result_stream_checker dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .clear(clear_a), .match_count(match_a), .mismatch_count(mismatch_a), .first_bad_idx(first_bad_a),
      .last_value(last_value_a), .done(done_a), .error(error_a)
   );

   kiwi_result_stream_checker #(.MAX_ITEMS(2)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .clear(clear_b), .match_count(match_b), .mismatch_count(mismatch_b), .first_bad_idx(first_bad_b),
      .last_value(last_value_b), .done(done_b), .error(error_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [31:0] v);
      in_valid_a = 1'b1;
      in_data_a  = v;
      tick(1);
      in_valid_a = 1'b0;
   endtask

   task automatic push_b(input logic [31:0] v);
      in_valid_b = 1'b1;
      in_data_b  = v;
      tick(1);
      in_valid_b = 1'b0;
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, "_ready"},    64'(in_ready_a),   64'd1);
      check({tag, "_match"},    64'(match_a),      64'd0);
      check({tag, "_mismatch"}, 64'(mismatch_a),   64'd0);
      check({tag, "_firstbad"}, 64'(first_bad_a),  64'd0);
      check({tag, "_last"},     64'(last_value_a), 64'd0);
      check({tag, "_done"},     64'(done_a),       64'd0);
      check({tag, "_error"},    64'(error_a),      64'd0);
   endtask

   initial begin
      reset = 1'b1;
      in_valid_a = 1'b0; in_data_a = '0; clear_a = 1'b0;
      in_valid_b = 1'b0; in_data_b = '0; clear_b = 1'b0;
      chain[0] = 32'd1;
      for (int i = 1; i < 6; i++) chain[i] = chain[i-1] * 32'd1001;

      // Reset state
      #2;
      check_idle_a("rst");
      check("rst_b_ready", 64'(in_ready_b), 64'd1);
      check("rst_b_done",  64'(done_b),     64'd0);
      @(negedge clk);
      reset = 1'b0;
      tick(1);

      // Test 1: first four terms back-to-back
      push_a(32'd1);
      push_a(32'd1001);
      push_a(32'd1002001);
      push_a(32'd1003003001);
      tick(1);
      check("t1_match",    64'(match_a),      64'd4);
      check("t1_mismatch", 64'(mismatch_a),   64'd0);
      check("t1_error",    64'(error_a),      64'd0);
      check("t1_last",     64'(last_value_a), 64'd1003003001);

      // Test 2: 1001^4 mod 2^32 = 1004006004001 - 233*2^32
      push_a(32'd3278624033);
      tick(1);
      check("t2_match", 64'(match_a),      64'd5);
      check("t2_last",  64'(last_value_a), 64'd3278624033);
      check("t2_error", 64'(error_a),      64'd0);

      // Test 3: one bad value at index 2, no cascade
      clear_a = 1'b1;
      tick(1);
      clear_a = 1'b0;
      check_idle_a("t3_clr");
      push_a(32'd1);
      push_a(32'd1001);
      push_a(32'd7);
      push_a(32'd1003003001);
      tick(1);
      check("t3_mismatch", 64'(mismatch_a),   64'd1);
      check("t3_firstbad", 64'(first_bad_a),  64'd2);
      check("t3_error",    64'(error_a),      64'd1);
      check("t3_match",    64'(match_a),      64'd3);
      check("t3_last",     64'(last_value_a), 64'd1003003001);

      // Test 4: MAX_ITEMS=2, six correct values then back-pressure
      for (int i = 0; i < 6; i++) begin
         in_valid_b = 1'b1;
         in_data_b  = chain[i];
         tick(1);
         if (i == 1) begin
            check("t4_done_early", 64'(done_b),  64'd0);
            check("t4_match1",     64'(match_b), 64'd1);
         end
         if (i == 2) begin
            check("t4_done",   64'(done_b),  64'd1);
            check("t4_match2", 64'(match_b), 64'd2);
         end
         if (i == 4) check("t4_ready_3buf", 64'(in_ready_b), 64'd1);
      end
      check("t4_ready_full", 64'(in_ready_b), 64'd0);
      in_data_b = 32'd55;
      tick(3);
      in_valid_b = 1'b0;
      check("t4_ready_hold", 64'(in_ready_b),   64'd0);
      check("t4_match_hold", 64'(match_b),      64'd2);
      check("t4_done_hold",  64'(done_b),       64'd1);
      check("t4_last_hold",  64'(last_value_b), 64'd1001);

      // Test 5: clear with three entries buffered; concurrent push is discarded
      clear_b = 1'b1;
      tick(1);
      clear_b = 1'b0;
      check("t5_pre_ready", 64'(in_ready_b), 64'd1);
      for (int i = 0; i < 5; i++) push_b(chain[i]);
      check("t5_3buf_ready", 64'(in_ready_b), 64'd1);
      check("t5_3buf_done",  64'(done_b),     64'd1);
      clear_b    = 1'b1;
      in_valid_b = 1'b1;
      in_data_b  = 32'd99;
      tick(1);
      clear_b    = 1'b0;
      in_valid_b = 1'b0;
      check("t5_ready",    64'(in_ready_b),   64'd1);
      check("t5_match",    64'(match_b),      64'd0);
      check("t5_mismatch", 64'(mismatch_b),   64'd0);
      check("t5_done",     64'(done_b),       64'd0);
      check("t5_last",     64'(last_value_b), 64'd0);
      push_b(32'd1);
      tick(1);
      check("t5_seed_match",    64'(match_b),      64'd1);
      check("t5_seed_mismatch", 64'(mismatch_b),   64'd0);
      check("t5_seed_last",     64'(last_value_b), 64'd1);

      // Test 6: async reset between edges with a value in flight
      in_valid_a = 1'b1;
      in_data_a  = 32'd3278624033;
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_idle_a("t6");
      check("t6_b_match", 64'(match_b), 64'd0);
      in_valid_a = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      push_a(32'd1);
      tick(1);
      check("t6_reseed_match",    64'(match_a),    64'd1);
      check("t6_reseed_mismatch", 64'(mismatch_a), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
